// File: rtl/bcd_if.sv
// Handshake bundle between the arithmetic datapath, the BCD converter and the display stage.
// The master drives words in and takes results out; the slave is the converter.
interface bcd_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  in_neg;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_neg;

    modport master (
        output in_valid, in_data, in_neg, out_ready,
        input  in_ready, out_valid, out_bcd, out_neg
    );

    modport slave (
        input  in_valid, in_data, in_neg, out_ready,
        output in_ready, out_valid, out_bcd, out_neg
    );
endinterface

// File: rtl/bcd_conv.sv
// Sequential binary-to-BCD converter using shift-add-3, one input bit per clock.
// Accepts a magnitude plus sign, presents packed decimal digits on a valid/ready port.
module bcd_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    bcd_if.slave   bus,
    output logic   busy
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_next;
    logic [BW-1:0]     bcd_q, bcd_adj, bcd_next;
    logic [CW-1:0]     cnt_q;
    logic              neg_q;
    logic [BW-1:0]     out_bcd_q;
    logic              out_neg_q;
    logic              load, step, finish;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_q == CW'(1)) begin
                    finish  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Add-3 correction is applied per digit before the shift; digits never carry into each other.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        {bcd_next, bin_next} = {bcd_adj, bin_q} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            out_bcd_q <= '0;
            out_neg_q <= 1'b0;
        end else if (load) begin
            bin_q <= bus.in_data;
            neg_q <= bus.in_neg;
            bcd_q <= '0;
            cnt_q <= CW'(WIDTH);
        end else if (step) begin
            bin_q <= bin_next;
            bcd_q <= bcd_next;
            cnt_q <= cnt_q - CW'(1);
            if (finish) begin
                out_bcd_q <= bcd_next;
                out_neg_q <= neg_q;
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_neg   = out_neg_q;
    assign busy          = (state_q == SHIFT);
endmodule

// File: doc/bcd_conv.md
Name: bcd_conv

Overview:
Sequential binary-to-BCD converter. It sits directly downstream of the 4-bit arithmetic datapath (adder/subtractor, 4x4 multiplier, divider). It takes one unsigned result word per transaction, plus a sign flag, and converts it with the shift-add-3 (double-dabble) algorithm, one bit per clock. The packed decimal digits and sign go to the display/formatting stage over a valid/ready handshake.

Parameters:
WIDTH, 8, binary input width (covers the 8-bit multiplier product; 5-bit adder results are zero-extended by the caller)
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream result present
in_ready  output  1  converter can accept a word
in_data  input  WIDTH  unsigned binary magnitude
in_neg  input  1  sign flag from upstream (1 = negative), captured with in_data
out_valid  output  1  conversion result available
out_ready  input  1  downstream accepts result
out_bcd  output  4*DIGITS  packed BCD, digit 0 (units) in [3:0]
out_neg  output  1  captured sign flag
busy  output  1  high in SHIFT state

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, on rst_n. While rst_n=0 the state goes to IDLE, out_valid=0, out_bcd=0, out_neg=0, busy=0, in_ready=1, and the internal shift and count registers clear.
- Reset mid-conversion or mid-HOLD aborts immediately. The word in flight is discarded and never presented.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1: latch in_data into the binary shift register and in_neg into the sign register, clear the BCD accumulator, load the counter with WIDTH, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge, in this order: every BCD digit >=5 gets +3 (4-bit add, no carry between digits); then the concatenation {bcd, bin} shifts left by 1; then the counter decrements.
  - When the counter reaches 0 (after exactly WIDTH shift edges), load out_bcd from the accumulator and go to HOLD.
- HOLD:
  - out_valid=1; out_bcd and out_neg stay stable until handshake.
  - On an edge with out_ready=1: out_valid drops, go to IDLE.
  - in_ready returns to 1 the cycle after the handshake. There is no same-cycle bypass from HOLD to accept.
- Latency:
  - Accept edge T. out_valid is high after edge T+WIDTH (8 cycles by default).
  - Minimum transaction period is WIDTH+2 cycles with out_ready held high.
- in_data and in_neg changes while not in IDLE are ignored.
- out_bcd is undefined-free: it holds its last value while out_valid=0. Downstream only uses it when out_valid=1.
- Width rules:
  - Accumulator is 4*DIGITS bits.
  - Bits shifted out of the top digit are discarded. This cannot happen when the DIGITS constraint holds.
  - If the constraint is violated, the upper decimal digits are truncated silently. No error flag.
- out_ready is a don't-care outside HOLD. out_ready high in IDLE or SHIFT has no effect.
- Every digit of out_bcd is always in 0..9 for legal inputs.

Test Plan:
- Reset then in_data=0, in_neg=0 -> out_valid 8 cycles after accept, out_bcd=12'h000, out_neg=0.
- in_data=255 -> out_bcd=12'h255. in_data=144 (12x12 product) with in_neg=1 -> out_bcd=12'h144, out_neg=1.
- Exhaustive sweep 0..255 with out_ready=1 -> each out_bcd equals the decimal encoding. Successive accepts are spaced exactly 10 cycles apart; in_ready is low for 9 of them.
- Back-pressure: in_data=99, out_ready=0 for 5 cycles after out_valid -> out_bcd=12'h099 held stable, in_ready=0 throughout. out_valid drops the cycle after out_ready=1.
- Reset mid-op: assert rst_n=0 asynchronously 3 cycles into SHIFT with in_data=200 -> outputs clear at once, no out_valid. Next conversion of 37 -> 12'h037.
- Input change during SHIFT: accept 58, then drive in_data=7 and in_valid=1 during conversion -> result 12'h058. 7 is accepted only after the handshake completes.
